dram_port_arb: RTL
==================

DRAM_PORT_ARB -- requirements
Module: dram_port_arb

Interface
REQ-001 SHALL have parameter DW, default 33: data width, bit DW-1 is the capability tag.
REQ-002 SHALL have parameter AW, default 30: word-address width.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive port-0 wins before port 1 is forced.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as follows:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
REQ-005 SHALL have the following requester ports (index 0 = CPU data, index 1 = background engine):
- req_i  input  2  request per port
- we_i  input  2  write enable per port
- be_i  input  2x4  byte enables per port
- addr_i  input  2xAW  word address per port
- wdata_i  input  2xDW  write data per port
- lock_i  input  2  keep ownership for the next beat
- gnt_o  output  2  one-hot grant (or zero)
- rvalid_o  output  2  response valid per port
- rdata_o  output  DW  read data, qualified by rvalid_o
- err_o  output  2  error response per port
REQ-006 SHALL have the following memory ports:
- mem_cs  output  1  memory select
- mem_we  output  1  memory write enable
- mem_be  output  4  memory byte enables
- mem_addr32  output  AW  memory word address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  read data, valid the cycle after mem_cs
- mem_err  input  1  error, valid in the same cycle as mem_cs

Function
REQ-007 Grant SHALL be combinational in the request cycle; at most one gnt_o bit high; gnt_o SHALL be 0 while rst_ni is low.
REQ-008 Owner FSM states: IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-009 In IDLE, a single requester SHALL be granted; when both request, port 0 SHALL win unless starve_cnt == STARVE_MAX, in which case port 1 SHALL win.
REQ-010 starve_cnt SHALL follow these rules:
- increments (saturating at STARVE_MAX) when req_i[1]=1 and port 0 is granted;
- clears when port 1 is granted or req_i[1]=0;
- holds otherwise; reset value 0.
REQ-011 A grant to port n with lock_i[n]=1 SHALL move the FSM to LOCKn.
REQ-012 In LOCKn, only port n SHALL be grantable; the other port's gnt SHALL be 0 and starve_cnt SHALL hold.
REQ-013 LOCKn exits SHALL behave as follows:
- granted beat with lock_i[n]=0: back to IDLE next cycle;
- req_i[n]=0: to IDLE with IDLE arbitration applied in that same cycle.
REQ-014 mem_cs SHALL equal |gnt_o; mem_we/be/addr32/wdata SHALL be the winner's inputs, and all-zero when mem_cs=0.
REQ-015 Response path:
- 1-entry register captures {port, we, mem_err} on each grant;
- the cycle after a grant, rvalid_o[port]=1 and err_o[port]=captured mem_err;
- rdata_o = mem_rdata for reads, 0 for writes or errors.
REQ-016 Back-to-back grants SHALL produce back-to-back responses (throughput 1/cycle), in grant order.
REQ-017 Outputs with no response pending: rvalid_o=0, err_o=0, rdata_o=0.
REQ-018 Tag bit DW-1 of write data SHALL pass unmodified; the arbiter SHALL NOT inspect or alter it.

Reset
REQ-019 rst_ni low SHALL asynchronously force FSM=IDLE, starve_cnt=0, response register empty (rvalid_o=0, err_o=0, rdata_o=0), gnt_o=0, mem_cs=0.
REQ-020 A grant issued in the cycle before reset asserts SHALL produce no response; the first cycle after release SHALL arbitrate from IDLE.

Verification
REQ-021 Single read: port 0 reads addr 0x2000_0010, mem_rdata=0x1_DEADBEEF next cycle -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o=0x1_DEADBEEF, err_o=00.
REQ-022 Starvation: both ports request continuously, STARVE_MAX=4 -> grants 0,0,0,0,1,0,0,0,0,1; exactly one response per cycle.
REQ-023 Lock: port 1 granted with lock_i[1]=1 for 2 beats, port 0 requesting throughout -> gnt_o=10,10,10, then 01; starve_cnt unchanged during the lock.
REQ-024 Error: port 1 write to addr 0x0000_0100 with mem_err=1 -> next cycle rvalid_o=10, err_o=10, rdata_o=0.
REQ-025 Reset mid-operation: rst_ni low in the cycle after a port 0 grant -> rvalid_o=0 immediately; after release, both ports requesting -> port 0 wins and starve_cnt=0.
REQ-026 Idle: req_i=00 -> mem_cs=0 and mem_addr32/wdata/be/we all 0; no rvalid next cycle.

Source files
------------

// File: rtl/dram_port_arb_if.sv
// Requester and memory bus bundle for the two-port DRAM arbiter.
// The arbiter attaches through the slave modport; requesters plus the
// memory model (or the bench) drive the master side.
interface dram_port_arb_if #(
  parameter int DW = 33,
  parameter int AW = 30
);
  // Requester side, index 0 = CPU data, index 1 = background engine
  logic [1:0]            req_i;
  logic [1:0]            we_i;
  logic [1:0][3:0]       be_i;
  logic [1:0][AW-1:0]    addr_i;
  logic [1:0][DW-1:0]    wdata_i;
  logic [1:0]            lock_i;
  logic [1:0]            gnt_o;
  logic [1:0]            rvalid_o;
  logic [DW-1:0]         rdata_o;
  logic [1:0]            err_o;

  // Memory side
  logic                  mem_cs;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [AW-1:0]         mem_addr32;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_rdata;
  logic                  mem_err;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, lock_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output mem_cs, mem_we, mem_be, mem_addr32, mem_wdata,
    input  mem_rdata, mem_err
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, lock_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  mem_cs, mem_we, mem_be, mem_addr32, mem_wdata,
    output mem_rdata, mem_err
  );
endinterface

// File: rtl/dram_port_arb.sv
// Two-port DRAM arbiter: CPU data port (0) has priority, the background
// engine (1) is forced through after STARVE_MAX consecutive port-0 wins.
// A port may hold ownership across beats with lock_i. Grants are
// combinational; responses come back one cycle later in grant order.
// Write data (including the capability tag in bit DW-1) is forwarded
// untouched.
module dram_port_arb #(
  parameter int DW         = 33,
  parameter int AW         = 30,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  dram_port_arb_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } own_e;

  own_e            state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [1:0]      idle_gnt;
  logic [1:0]      gnt;
  logic            lock_beat;

  logic            mem_cs_c;
  logic            mem_we_c;
  logic [3:0]      mem_be_c;
  logic [AW-1:0]   mem_addr_c;
  logic [DW-1:0]   mem_wdata_c;

  logic            rsp_vld_q;
  logic            rsp_port_q;
  logic            rsp_we_q;
  logic            rsp_err_q;

  logic [1:0]      rsp_sel;
  logic [1:0]      rvalid_c;
  logic [1:0]      err_c;
  logic [DW-1:0]   rdata_c;

  // Free arbitration: fixed priority to port 0 unless port 1 is starved
  always_comb begin
    idle_gnt = 2'b00;
    if (bus.req_i[0] && bus.req_i[1]) begin
      idle_gnt = (starve_q == STARVE_LIM) ? 2'b10 : 2'b01;
    end else if (bus.req_i[0]) begin
      idle_gnt = 2'b01;
    end else if (bus.req_i[1]) begin
      idle_gnt = 2'b10;
    end
  end

  // Ownership: a locked owner that still requests keeps the bus, a locked
  // owner that drops its request hands over to free arbitration this cycle
  always_comb begin
    lock_beat = 1'b0;
    gnt       = idle_gnt;
    case (state_q)
      LOCK0: begin
        if (bus.req_i[0]) begin
          lock_beat = 1'b1;
          gnt       = 2'b01;
        end
      end
      LOCK1: begin
        if (bus.req_i[1]) begin
          lock_beat = 1'b1;
          gnt       = 2'b10;
        end
      end
      default: ;
    endcase
    if (!rst_ni) begin
      gnt = 2'b00;
    end
  end

  // Next owner state and starvation count; the count is frozen on locked beats
  always_comb begin
    state_d  = IDLE;
    starve_d = starve_q;
    if (gnt[0] && bus.lock_i[0]) begin
      state_d = LOCK0;
    end else if (gnt[1] && bus.lock_i[1]) begin
      state_d = LOCK1;
    end
    if (!lock_beat) begin
      if (gnt[1] || !bus.req_i[1]) begin
        starve_d = '0;
      end else if (gnt[0] && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Owner FSM and starvation counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Route the winner's command to memory; drive zeros when nobody wins
  always_comb begin
    mem_cs_c    = |gnt;
    mem_we_c    = 1'b0;
    mem_be_c    = 4'b0000;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (gnt[0]) begin
      mem_we_c    = bus.we_i[0];
      mem_be_c    = bus.be_i[0];
      mem_addr_c  = bus.addr_i[0];
      mem_wdata_c = bus.wdata_i[0];
    end else if (gnt[1]) begin
      mem_we_c    = bus.we_i[1];
      mem_be_c    = bus.be_i[1];
      mem_addr_c  = bus.addr_i[1];
      mem_wdata_c = bus.wdata_i[1];
    end
  end

  // One-entry response slot, refilled on every cycle so back-to-back
  // grants stream responses at one per cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
      rsp_we_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_vld_q  <= mem_cs_c;
      rsp_port_q <= gnt[1];
      rsp_we_q   <= mem_we_c;
      rsp_err_q  <= mem_cs_c & bus.mem_err;
    end
  end

  // Decode the pending response onto the owning port; read data only
  // for error-free reads
  always_comb begin
    rsp_sel  = rsp_port_q ? 2'b10 : 2'b01;
    rvalid_c = rsp_vld_q ? rsp_sel : 2'b00;
    err_c    = (rsp_vld_q && rsp_err_q) ? rsp_sel : 2'b00;
    rdata_c  = '0;
    if (rsp_vld_q && !rsp_we_q && !rsp_err_q) begin
      rdata_c = bus.mem_rdata;
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.mem_cs     = mem_cs_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_be     = mem_be_c;
  assign bus.mem_addr32 = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.rvalid_o   = rvalid_c;
  assign bus.err_o      = err_c;
  assign bus.rdata_o    = rdata_c;

  // Grant is never shared between ports
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt));

  // A locked owner that keeps requesting is never overtaken
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCK1 && bus.req_i[1]) |-> gnt == 2'b10);

endmodule
